rx_cmd_parser: RTL

Command-frame parser directly downstream of the UART receiver. Consumes the byte stream (`P_DATA`/`data_valid` plus error flags) and decodes the system command protocol into register-file write/read strobes and ALU launch controls. Aborts stalled frames with a timeout counter. Sits between the UART RX top and the register file / ALU in the system controller.

---
 rtl/rx_cmd_parser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rx_cmd_parser.sv
// Command-frame parser behind the UART receiver: decodes AA/BB/CC/DD frames into
// register-file and ALU strobes, with an inter-byte timeout. Optional feature: RX_ERR_DROP_EN.
module rx_cmd_parser #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_par_err,
    input  logic              rx_frm_err,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    output logic [3:0]        alu_fun,
    output logic              alu_en,
    output logic              alu_clk_en,
    output logic              bad_cmd,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_FUN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_en, r_rd_en, r_alu_en, r_alu_clk_en, r_bad, r_ferr, r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wr_data;
    logic [3:0]        r_alu_fun;

    logic              w_drop, w_acc, w_timeout;
    logic              w_wr_en, w_rd_en, w_alu_en, w_bad, w_ferr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_data_nxt;
    logic [3:0]        w_fun_nxt;

`ifdef RX_ERR_DROP_EN
    assign w_drop = rx_valid & (rx_par_err | rx_frm_err);
`else
    logic w_unused_err;
    assign w_unused_err = rx_par_err | rx_frm_err;
    assign w_drop       = 1'b0;
`endif

    assign w_acc     = rx_valid & ~w_drop;
    // A byte in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != S_IDLE) & ~rx_valid & (r_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_alu_en    = 1'b0;
        w_bad       = 1'b0;
        w_ferr      = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_wr_data;
        w_fun_nxt   = r_alu_fun;
        if (w_drop) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end else if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    case (rx_data)
                        8'hAA:   w_state_nxt = S_WR_ADDR;
                        8'hBB:   w_state_nxt = S_RD_ADDR;
                        8'hCC:   w_state_nxt = S_OP_A;
                        8'hDD:   w_state_nxt = S_FUN;
                        default: w_bad       = 1'b1;
                    endcase
                end
                S_WR_ADDR: begin
                    w_addr_nxt  = rx_data[ADDR_W-1:0];
                    w_state_nxt = S_WR_DATA;
                end
                S_WR_DATA: begin
                    w_data_nxt  = rx_data;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_RD_ADDR: begin
                    w_addr_nxt  = rx_data[ADDR_W-1:0];
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_OP_A: begin
                    w_addr_nxt  = '0;
                    w_data_nxt  = rx_data;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_OP_B;
                end
                S_OP_B: begin
                    w_addr_nxt  = ADDR_W'(1);
                    w_data_nxt  = rx_data;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_FUN;
                end
                S_FUN: begin
                    w_fun_nxt   = rx_data[3:0];
                    w_alu_en    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_alu_en     <= 1'b0;
            r_alu_clk_en <= 1'b0;
            r_bad        <= 1'b0;
            r_ferr       <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_alu_fun    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= (w_state_nxt == S_IDLE || rx_valid) ? '0 : r_cnt + 1'b1;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_alu_en  <= w_alu_en;
            r_bad     <= w_bad;
            r_ferr    <= w_ferr;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_data_nxt;
            r_alu_fun <= w_fun_nxt;
            // ALU clock stays on across the operand/function bytes and the launch cycle.
            r_alu_clk_en <= (w_state_nxt == S_OP_A) | (w_state_nxt == S_OP_B) |
                            (w_state_nxt == S_FUN)  | w_alu_en;
        end
    end

    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign reg_addr    = r_addr;
    assign reg_wr_data = r_wr_data;
    assign alu_fun     = r_alu_fun;
    assign alu_en      = r_alu_en;
    assign alu_clk_en  = r_alu_clk_en;
    assign bad_cmd     = r_bad;
    assign frame_err   = r_ferr;
    assign busy        = r_busy;

endmodule
